// File: rtl/bpred_unit.sv
// Branch-prediction unit: configurable PHT indexing, tagged direct-mapped BTB,
// global history register and resolved/mispredict counters.
module bpred_unit #(
  parameter int GHR_W  = 4,
  parameter int IDX_W  = 6,
  parameter int BTB_AW = 4,
  parameter int MODE   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       lk_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              up_valid,
  input  logic [31:0]       up_pc,
  input  logic              up_is_br,
  input  logic              up_is_jal,
  input  logic              up_taken,
  input  logic [31:0]       up_target,
  input  logic              up_mispred,
  input  logic              clr,
  output logic [GHR_W-1:0]  ghr,
  output logic [31:0]       stat_upd,
  output logic [31:0]       stat_mis
);

  localparam int PHT_N = 1 << IDX_W;
  localparam int BTB_N = 1 << BTB_AW;
  localparam int TAG_W = 30 - BTB_AW;
  // PC bits kept below the history in concatenated mode (guarded so the
  // expression stays legal when that mode is not selected).
  localparam int LOW_W = (IDX_W > GHR_W) ? (IDX_W - GHR_W) : 1;

  logic [1:0]        pht     [PHT_N];
  logic [BTB_N-1:0]  btb_v;
  logic [BTB_N-1:0]  btb_kind;
  logic [TAG_W-1:0]  btb_tag [BTB_N];
  logic [31:0]       btb_tgt [BTB_N];
  logic [GHR_W-1:0]  ghr_q;
  logic [31:0]       upd_q;
  logic [31:0]       mis_q;

  // PHT index for a PC under the current history; history is zero-extended
  // into a wide temporary so every mode uses in-range slices.
  function automatic logic [IDX_W-1:0] pht_idx(input logic [31:0] pc,
                                                input logic [GHR_W-1:0] h);
    logic [IDX_W+GHR_W-1:0] hx;
    logic [IDX_W-1:0]       pcw;
    logic [IDX_W-1:0]       lo_mask;
    hx          = '0;
    hx[GHR_W-1:0] = h;
    pcw         = pc[IDX_W+1:2];
    lo_mask     = IDX_W'((64'd1 << LOW_W) - 64'd1);
    if (MODE == 0)
      return pcw;
    else if (MODE == 1)
      return pcw ^ hx[IDX_W-1:0];
    else
      return (hx[IDX_W-1:0] << LOW_W) | (pcw & lo_mask);
  endfunction

  logic [BTB_AW-1:0] lk_bi;
  logic [IDX_W-1:0]  lk_pi;
  logic [BTB_AW-1:0] up_bi;
  logic [IDX_W-1:0]  up_pi;
  logic              ev;
  logic              br_upd;
  logic              btb_wr;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^{lk_pc[1:0], up_pc[1:0]};

  // Lookup path: purely combinational from registered state, no bypass of
  // an update presented in the same cycle. Forced to a miss while in reset.
  always_comb begin
    lk_bi       = lk_pc[BTB_AW+1:2];
    lk_pi       = pht_idx(lk_pc, ghr_q);
    pred_hit    = rstn && btb_v[lk_bi] && (btb_tag[lk_bi] == lk_pc[31:BTB_AW+2]);
    pred_taken  = pred_hit && (btb_kind[lk_bi] || pht[lk_pi][1]);
    pred_target = pred_taken ? btb_tgt[lk_bi] : (lk_pc + 32'd4);
  end

  // Update qualification; JAL takes precedence when both type flags are set.
  always_comb begin
    ev     = up_valid && (up_is_br || up_is_jal);
    br_upd = ev && up_is_br && !up_is_jal;
    btb_wr = ev && (up_is_jal || (up_is_br && up_taken));
    up_bi  = up_pc[BTB_AW+1:2];
    up_pi  = pht_idx(up_pc, ghr_q);
  end

  // PHT saturating counters, indexed with the pre-shift history.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (br_upd) begin
      if (up_taken && pht[up_pi] != 2'b11)
        pht[up_pi] <= pht[up_pi] + 2'b01;
      else if (!up_taken && pht[up_pi] != 2'b00)
        pht[up_pi] <= pht[up_pi] - 2'b01;
    end
  end

  // Global history shifts in each resolved conditional branch outcome.
  always_ff @(posedge clk) begin
    if (!rstn)
      ghr_q <= '0;
    else if (br_upd)
      ghr_q <= (ghr_q << 1) | GHR_W'(up_taken);
  end

  // BTB valid bits; clear beats a same-cycle allocation.
  always_ff @(posedge clk) begin
    if (!rstn)
      btb_v <= '0;
    else if (clr)
      btb_v <= '0;
    else if (btb_wr)
      btb_v[up_bi] <= 1'b1;
  end

  // BTB payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[up_bi]  <= up_pc[31:BTB_AW+2];
      btb_tgt[up_bi]  <= up_target;
      btb_kind[up_bi] <= up_is_jal;
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      upd_q <= '0;
      mis_q <= '0;
    end else begin
      if (ev) upd_q <= upd_q + 32'd1;
      if (ev && up_mispred) mis_q <= mis_q + 32'd1;
    end
  end

  assign ghr      = ghr_q;
  assign stat_upd = upd_q;
  assign stat_mis = mis_q;

endmodule

// File: tb/tb_bpred_unit.sv
// Bench for bpred_unit: three instances (bimodal, gshare, concatenated) share
// one stimulus stream and are checked against an arithmetic reference model.
module tb_bpred_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] lk_pc;
  logic        up_valid, up_is_br, up_is_jal, up_taken, up_mispred, clr;
  logic [31:0] up_pc, up_target;

  logic [2:0]        hit_o, tkn_o;
  logic [2:0][31:0]  tgt_o, upd_o, mis_o;
  logic [2:0][3:0]   ghr_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bpred_unit #(.GHR_W(4), .IDX_W(6), .BTB_AW(4), .MODE(g)) u_dut (
      .clk(clk), .rstn(rstn), .lk_pc(lk_pc),
      .pred_hit(hit_o[g]), .pred_taken(tkn_o[g]), .pred_target(tgt_o[g]),
      .up_valid(up_valid), .up_pc(up_pc), .up_is_br(up_is_br),
      .up_is_jal(up_is_jal), .up_taken(up_taken), .up_target(up_target),
      .up_mispred(up_mispred), .clr(clr), .ghr(ghr_o[g]),
      .stat_upd(upd_o[g]), .stat_mis(mis_o[g])
    );
  end

  // ---------------- reference model ----------------
  int          m_pht [3][64];
  bit          m_v   [16];
  bit          m_jal [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int unsigned m_ghr, m_upd, m_mis;

  function automatic int unsigned midx(int m, int unsigned pc, int unsigned h);
    int unsigned w;
    w = (pc / 4) % 64;
    if (m == 0) return w;
    if (m == 1) return (w ^ h) % 64;
    return h * 4 + (pc / 4) % 4;
  endfunction

  function automatic void mreset();
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 64; i++) m_pht[m][i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    m_ghr = 0; m_upd = 0; m_mis = 0;
  endfunction

  function automatic void mpred(input int m, input int unsigned pc,
                                output bit h, output bit t, output int unsigned tg);
    int unsigned e;
    e  = (pc / 4) % 16;
    h  = rstn && m_v[e] && (m_tag[e] == pc / 64);
    t  = h && (m_jal[e] || m_pht[m][midx(m, pc, m_ghr)] >= 2);
    tg = t ? m_tgt[e] : pc + 4;
  endfunction

  function automatic void model_edge();
    bit ev, isj, isb;
    int unsigned e, i;
    if (!rstn) begin
      mreset();
      return;
    end
    ev  = up_valid && (up_is_br || up_is_jal);
    isj = ev && up_is_jal;
    isb = ev && up_is_br && !up_is_jal;
    if (ev) m_upd++;
    if (ev && up_mispred) m_mis++;
    if (isb) begin
      for (int m = 0; m < 3; m++) begin
        i = midx(m, up_pc, m_ghr);
        if (up_taken) m_pht[m][i] = (m_pht[m][i] < 3) ? m_pht[m][i] + 1 : 3;
        else          m_pht[m][i] = (m_pht[m][i] > 0) ? m_pht[m][i] - 1 : 0;
      end
      m_ghr = (m_ghr * 2 + int'(up_taken)) % 16;
    end
    if (isj || (isb && up_taken)) begin
      e = (up_pc / 4) % 16;
      m_v[e] = 1; m_tag[e] = up_pc / 64; m_tgt[e] = up_target; m_jal[e] = isj;
    end
    if (clr)
      for (int k = 0; k < 16; k++) m_v[k] = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    up_valid = 0; up_is_br = 0; up_is_jal = 0; up_taken = 0;
    up_mispred = 0; clr = 0; up_pc = 0; up_target = 0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input bit br, input bit jal,
                         input bit tk, input logic [31:0] tgt, input bit mis);
    up_valid = 1; up_pc = pc; up_is_br = br; up_is_jal = jal;
    up_taken = tk; up_target = tgt; up_mispred = mis;
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    tick(); tick();
    rstn = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rstn  = 0;
    lk_pc = 32'h40;
    tick(); tick();
    #2;
    n_chk++;
    if (hit_o !== 3'b000 || tkn_o !== 3'b000) begin
      n_fail++; $display("FAIL reset_during_pred: hit=%b taken=%b expected 000/000", hit_o, tkn_o);
    end
    rstn = 1;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (hit_o[g] !== 1'b0 || tkn_o[g] !== 1'b0 || tgt_o[g] !== 32'h44) begin
        n_fail++; $display("FAIL reset_pred[%0d]: hit=%b taken=%b target=%h expected 0/0/00000044",
                           g, hit_o[g], tkn_o[g], tgt_o[g]);
      end
      n_chk++;
      if (ghr_o[g] !== 4'h0 || upd_o[g] !== 32'd0 || mis_o[g] !== 32'd0) begin
        n_fail++; $display("FAIL reset_state[%0d]: ghr=%h upd=%0d mis=%0d expected 0/0/0",
                           g, ghr_o[g], upd_o[g], mis_o[g]);
      end
    end
  endtask

  task automatic test_bimodal();
    do_reset();
    lk_pc = 32'h40;
    set_upd(32'h40, 1, 0, 1, 32'h20, 0);
    tick(); idle(); #2;
    n_chk++;
    if (hit_o[0] !== 1'b1 || tkn_o[0] !== 1'b1 || tgt_o[0] !== 32'h20) begin
      n_fail++; $display("FAIL bimodal_train: hit=%b taken=%b target=%h expected 1/1/00000020",
                         hit_o[0], tkn_o[0], tgt_o[0]);
    end
    repeat (3) begin set_upd(32'h40, 1, 0, 1, 32'h20, 0); tick(); end
    set_upd(32'h40, 1, 0, 0, 32'h20, 0); tick(); idle(); #2;
    n_chk++;
    if (tkn_o[0] !== 1'b1 || tgt_o[0] !== 32'h20) begin
      n_fail++; $display("FAIL bimodal_saturate: taken=%b target=%h expected 1/00000020", tkn_o[0], tgt_o[0]);
    end
    repeat (2) begin set_upd(32'h40, 1, 0, 0, 32'h20, 0); tick(); end
    idle(); #2;
    n_chk++;
    if (hit_o[0] !== 1'b1 || tkn_o[0] !== 1'b0 || tgt_o[0] !== 32'h44) begin
      n_fail++; $display("FAIL bimodal_untrain: hit=%b taken=%b target=%h expected 1/0/00000044",
                         hit_o[0], tkn_o[0], tgt_o[0]);
    end
  endtask

  task automatic test_jal_alias();
    do_reset();
    set_upd(32'h100, 0, 1, 0, 32'h180, 0);
    tick(); idle();
    lk_pc = 32'h100; #2;
    n_chk++;
    if (tkn_o[1] !== 1'b1 || tgt_o[1] !== 32'h180 || ghr_o[1] !== 4'h0 || upd_o[1] !== 32'd1) begin
      n_fail++; $display("FAIL jal_predict: taken=%b target=%h ghr=%h upd=%0d expected 1/00000180/0/1",
                         tkn_o[1], tgt_o[1], ghr_o[1], upd_o[1]);
    end
    set_upd(32'h140, 1, 0, 1, 32'h1C0, 0);
    tick(); idle(); #2;
    n_chk++;
    if (hit_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL btb_alias: hit=%b expected 0", hit_o[1]);
    end
    // both type flags set: behaves as a JAL, history untouched
    set_upd(32'h200, 1, 1, 0, 32'h480, 0);
    tick(); idle();
    lk_pc = 32'h200; #2;
    n_chk++;
    if (tkn_o[1] !== 1'b1 || tgt_o[1] !== 32'h480 || ghr_o[1] !== 4'h1) begin
      n_fail++; $display("FAIL br_and_jal: taken=%b target=%h ghr=%h expected 1/00000480/1",
                         tkn_o[1], tgt_o[1], ghr_o[1]);
    end
  endtask

  task automatic test_history();
    bit   outcome [4] = '{1, 1, 0, 1};
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_upd(32'h40 + 32'(i * 4), 1, 0, outcome[i], 32'h800, 0);
      tick(); idle(); #2;
      for (int g = 0; g < 3; g++) begin
        n_chk++;
        if (ghr_o[g] !== exp_g[i]) begin
          n_fail++; $display("FAIL ghr_shift[%0d] step %0d: ghr=%b expected %b", g, i, ghr_o[g], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_races();
    do_reset();
    lk_pc = 32'h40;
    set_upd(32'h40, 1, 0, 1, 32'h20, 0);
    #2;
    n_chk++;
    if (hit_o !== 3'b000) begin
      n_fail++; $display("FAIL same_cycle_bypass: hit=%b expected 000", hit_o);
    end
    tick(); idle(); #2;
    n_chk++;
    if (hit_o !== 3'b111) begin
      n_fail++; $display("FAIL next_cycle_visible: hit=%b expected 111", hit_o);
    end
    set_upd(32'h80, 1, 0, 1, 32'h300, 0);
    clr = 1;
    tick(); idle();
    lk_pc = 32'h80; #2;
    n_chk++;
    if (hit_o !== 3'b000) begin
      n_fail++; $display("FAIL clr_wins: hit=%b expected 000", hit_o);
    end
    lk_pc = 32'h40; #1;
    n_chk++;
    if (hit_o !== 3'b000 || tgt_o[0] !== 32'h44) begin
      n_fail++; $display("FAIL clr_all: hit=%b target=%h expected 000/00000044", hit_o, tgt_o[0]);
    end
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_upd(32'h40 + 32'(i * 8), bit'(i % 2), bit'((i + 1) % 2), 1, 32'h900, bit'(i == 1 || i == 3));
      tick();
    end
    // not a control transfer / not valid: neither counts
    set_upd(32'h60, 0, 0, 1, 32'h900, 1); tick();
    set_upd(32'h60, 1, 0, 1, 32'h900, 1); up_valid = 0; tick();
    idle(); #2;
    n_chk++;
    if (upd_o[2] !== 32'd5 || mis_o[2] !== 32'd2) begin
      n_fail++; $display("FAIL counters: upd=%0d mis=%0d expected 5/2", upd_o[2], mis_o[2]);
    end
    set_upd(32'hC0, 1, 0, 1, 32'h400, 1);
    clr  = 1;
    rstn = 0;
    tick();
    rstn = 1; idle();
    lk_pc = 32'hC0; #2;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (upd_o[g] !== 32'd0 || mis_o[g] !== 32'd0 || ghr_o[g] !== 4'h0 || hit_o[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_update[%0d]: upd=%0d mis=%0d ghr=%h hit=%b expected 0/0/0/0",
                           g, upd_o[g], mis_o[g], ghr_o[g], hit_o[g]);
      end
    end
    lk_pc = 32'h40; #1;
    n_chk++;
    if (hit_o !== 3'b000) begin
      n_fail++; $display("FAIL reset_clears_btb: hit=%b expected 000", hit_o);
    end
  endtask

  task automatic test_random();
    bit          eh, et;
    int unsigned eg;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rstn       = ($urandom_range(0, 79) != 0);
      clr        = ($urandom_range(0, 39) == 0);
      up_valid   = ($urandom_range(0, 3) != 0);
      up_is_br   = ($urandom_range(0, 3) != 0);
      up_is_jal  = ($urandom_range(0, 4) == 0);
      up_taken   = $urandom_range(0, 1);
      up_mispred = ($urandom_range(0, 3) == 0);
      up_pc      = 32'($urandom_range(0, 127)) << 2;
      up_target  = $urandom() & 32'hFFFF_FFFC;
      lk_pc      = ($urandom_range(0, 3) == 0) ? up_pc : (32'($urandom_range(0, 127)) << 2);
      if ($urandom_range(0, 15) == 0) lk_pc = 32'hFFFF_FFFC;
      #2;
      for (int g = 0; g < 3; g++) begin
        mpred(g, lk_pc, eh, et, eg);
        n_chk++;
        if (hit_o[g] !== eh || tkn_o[g] !== et || tgt_o[g] !== eg) begin
          n_fail++; $display("FAIL rand_pred[%0d] cyc %0d pc=%h: hit=%b taken=%b target=%h expected %b/%b/%h",
                             g, c, lk_pc, hit_o[g], tkn_o[g], tgt_o[g], eh, et, eg);
        end
        n_chk++;
        if (ghr_o[g] !== 4'(m_ghr) || upd_o[g] !== m_upd || mis_o[g] !== m_mis) begin
          n_fail++; $display("FAIL rand_state[%0d] cyc %0d: ghr=%h upd=%0d mis=%0d expected %h/%0d/%0d",
                             g, c, ghr_o[g], upd_o[g], mis_o[g], m_ghr, m_upd, m_mis);
        end
      end
      tick();
    end
    rstn = 1; idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 0;
    lk_pc = 0;
    idle();
    mreset();
    @(negedge clk);
    test_reset();
    test_bimodal();
    test_jal_alias();
    test_history();
    test_races();
    test_counters();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bpred_unit.md
# bpred_unit

Parametrised branch-prediction unit for the five-stage RISC-V pipeline. It replaces the fixed 4-bit-GHR / 16×16 saturating-counter arrangement with a configurable PHT indexing mode, a tagged direct-mapped BTB, and performance counters. The lookup port serves the fetch/decode side with a same-cycle prediction. The update port is driven from EX when a branch or jump resolves.

## Interface
- `GHR_W`, default 4: global history register width, 1..16.
- `IDX_W`, default 6: PHT index width; the PHT holds 2^IDX_W 2-bit counters. Must satisfy IDX_W > GHR_W when MODE=2.
- `BTB_AW`, default 4: BTB index width; the BTB has 2^BTB_AW entries.
- `MODE`, default 1: PHT index mode. 0 = bimodal, 1 = gshare (XOR), 2 = concatenated {GHR, PC}.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `lk_pc`  in  32  PC to predict.
- `pred_hit`  out  1  BTB holds a valid entry with a matching tag for `lk_pc`.
- `pred_taken`  out  1  predicted redirect.
- `pred_target`  out  32  predicted next PC.
- `up_valid`  in  1  a resolved control-transfer instruction is presented this cycle.
- `up_pc`  in  32  PC of the resolved instruction.
- `up_is_br`  in  1  the instruction is a conditional branch.
- `up_is_jal`  in  1  the instruction is a JAL.
- `up_taken`  in  1  actual branch outcome; ignored for JAL.
- `up_target`  in  32  actual taken target.
- `up_mispred`  in  1  the pipeline detected a misprediction for this instruction.
- `clr`  in  1  synchronous BTB invalidate.
- `ghr`  out  GHR_W  current global history, for debug.
- `stat_upd`  out  32  count of resolved branches and JALs.
- `stat_mis`  out  32  count of mispredictions.

## Operation
- **PHT index `idx(pc)`.**
  - MODE 0: `pc[IDX_W+1:2]`.
  - MODE 1: `pc[IDX_W+1:2] ^ {0, ghr}`.
  - MODE 2: `{ghr, pc[IDX_W-GHR_W+1:2]}`.
- **BTB entry.** Each entry holds `valid`, `tag = pc[31:BTB_AW+2]`, `target[31:0]` and `kind` (0 = branch, 1 = JAL). The entry is selected by `pc[BTB_AW+1:2]`.
- **Lookup (combinational from registered state).**
  - `pred_hit` = valid && tag match.
  - `pred_taken` = `pred_hit` && (kind == 1 || `PHT[idx(lk_pc)][1]`).
  - `pred_target` = `pred_taken` ? entry target : `lk_pc + 4`, computed modulo 2^32.
- **Update.** Qualify `ev = up_valid && (up_is_br || up_is_jal)`. If both `up_is_br` and `up_is_jal` are set, the instruction is treated as a JAL.
  - **Branch:** the PHT counter at `idx(up_pc)` is computed with `ghr` *before* the shift. It saturates: taken increments and stops at 2'b11; not-taken decrements and stops at 2'b00. `ghr <= {ghr[GHR_W-2:0], up_taken}`; for GHR_W=1, `ghr <= up_taken`.
  - **BTB write:** on a taken branch or any JAL, write the BTB entry for `up_pc` as `{1, tag, up_target, up_is_jal}`, overwriting any alias.
  - A not-taken branch does not allocate and does not invalidate.
  - A JAL does not touch the PHT or `ghr`.
- **Counters.**
  - `stat_upd` increments on `ev`.
  - `stat_mis` increments on `ev && up_mispred`.
  - Both wrap from 0xFFFF_FFFF to 0.
- **`clr`.** Clears all BTB valid bits. The PHT, `ghr` and the counters are unaffected. If `clr` and a BTB write occur in the same cycle, `clr` wins and the entry ends invalid.
- **Reset (`rstn` = 0 at an edge).**
  - Reset values: every PHT counter = 2'b01, BTB valid = 0, `ghr` = 0, `stat_upd` = `stat_mis` = 0.
  - Reset overrides any concurrent update or `clr`.
  - Outputs during and after reset: `pred_hit` = 0, `pred_taken` = 0, `pred_target` = `lk_pc + 4`.

## Timing
- Lookup latency is 0 cycles: outputs depend combinationally on `lk_pc` and on state registered at the last edge.
- Update latency is 1 cycle: an update presented in cycle N is visible to a lookup in cycle N+1.
- A lookup in the same cycle as an update to the same PHT or BTB index returns the pre-update value; there is no bypass.
- `ghr` changes only on the edge that ends a cycle with a branch update.
- Maximum throughput: one lookup and one update per cycle.

## Test plan
- **Reset values:** assert `rstn` = 0 for 2 cycles, then lookup `lk_pc` = 0x40 → `pred_hit` = 0, `pred_taken` = 0, `pred_target` = 0x44, `ghr` = 0, both stats = 0.
- **Bimodal training and saturation (MODE=0):**
  - One taken branch update at `up_pc` = 0x40, `up_target` = 0x20, then lookup 0x40 → hit = 1, taken = 1, target = 0x20.
  - Three more taken updates, then one not-taken → still taken (counter 2'b10).
  - Two further not-taken updates → taken = 0, hit = 1, target = 0x44.
- **JAL and aliasing (MODE=1):**
  - JAL update at `up_pc` = 0x100, `up_target` = 0x180 → lookup 0x100 gives taken = 1, target = 0x180; `ghr` unchanged; `stat_upd` = 1.
  - With BTB_AW=4, a taken branch at 0x140 (same index, different tag) → lookup 0x100 gives hit = 0.
- **History shift (GHR_W=4):** from reset, branch updates taken, taken, not-taken, taken → `ghr` sequence 0001, 0011, 0110, 1101.
- **Same-cycle and clear races:**
  - Lookup 0x40 in the same cycle as the first taken update to 0x40 → hit = 0 that cycle, hit = 1 the next cycle.
  - `clr` together with a taken update to 0x80 → lookup 0x80 next cycle gives hit = 0.
- **Counters and reset mid-operation:**
  - 5 updates with 2 flagged `up_mispred` → `stat_upd` = 5, `stat_mis` = 2.
  - Assert `rstn` = 0 during an active update → update dropped, all state at reset values next cycle.
